// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared RV32M encodings and op-class helpers
package muldiv_seq_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mop_e;

  function automatic logic is_div_op(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] f);
    return f inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input logic [2:0] f);
    return f inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - EXE-side request/response bundle for the M-unit
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            req_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_val_i;
  logic [XLEN-1:0] rs2_val_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output req_i, funct3_i, rs1_val_i, rs2_val_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  req_i, funct3_i, rs1_val_i, rs2_val_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one radix-2 shift-add or restoring shift-subtract step
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Multiply: hi is the running partial product, lo the multiplier shifting out.
  // Divide: hi is the partial remainder, lo the dividend shifting into quotient.
  always_comb begin
    sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
    rem_sh = {hi_i, lo_i[XLEN-1]};
    diff   = rem_sh - {1'b0, opb_i};
    hi_o   = sum[XLEN:1];
    lo_o   = {sum[0], lo_i[XLEN-1:1]};
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = rem_sh[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide unit with pipeline stall
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            sa_q, sa_d, sb_q, sb_d;

  logic [XLEN-1:0]   hi_n, lo_n;
  logic              a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fin_res;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div_i (op_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opb_i    (opb_q),
    .hi_o     (hi_n),
    .lo_o     (lo_n)
  );

  always_comb begin
    a_neg = a_signed(bus.funct3_i) & bus.rs1_val_i[XLEN-1];
    b_neg = b_signed(bus.funct3_i) & bus.rs2_val_i[XLEN-1];
    mag_a = a_neg ? -bus.rs1_val_i : bus.rs1_val_i;
    mag_b = b_neg ? -bus.rs2_val_i : bus.rs2_val_i;
    div0  = is_div_op(bus.funct3_i) && (bus.rs2_val_i == '0);
    ovf   = (bus.funct3_i == OP_DIV || bus.funct3_i == OP_REM)
            && (bus.rs1_val_i == {1'b1, {(XLEN-1){1'b0}}})
            && (bus.rs2_val_i == '1);
  end

  // Sign correction uses the last step's outputs so the result lands on FINISH entry.
  always_comb begin
    prod    = {hi_n, lo_n};
    prod_s  = (sa_q ^ sb_q) ? -prod : prod;
    quot_s  = (sa_q ^ sb_q) ? -lo_n : lo_n;
    rem_s   = sa_q ? -hi_n : hi_n;
    case (op_q)
      OP_MUL:                       fin_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = quot_s;
      default:                      fin_res = rem_s;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_i && !bus.flush_i) begin
          op_d  = bus.funct3_i;
          sa_d  = a_neg;
          sb_d  = b_neg;
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = is_div_op(bus.funct3_i) ? mag_a : mag_b;
          opb_d = is_div_op(bus.funct3_i) ? mag_b : mag_a;
          if (div0) begin
            state_d  = S_FINISH;
            result_d = bus.funct3_i[1] ? bus.rs1_val_i : '1;
          end else if (ovf) begin
            state_d  = S_FINISH;
            result_d = bus.funct3_i[1] ? '0 : bus.rs1_val_i;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = hi_n;
          lo_d  = lo_n;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) begin
            state_d  = S_FINISH;
            result_d = fin_res;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.done_o   = (state_q == S_FINISH) && !bus.flush_i;
  assign bus.stall_o  = bus.req_i && !bus.done_o;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;
  localparam int XLEN = 32;
  localparam int ITER = 32;
  localparam int NORM_LAT = ITER + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();

  muldiv_seq #(.XLEN(XLEN), .ITER(ITER)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Request and operands must hold while the unit is working.
  logic [31:0] p_a, p_b;
  logic [2:0]  p_f;
  always @(posedge clk) begin
    if (rst_n && bus.busy_o && !bus.flush_i && !bus.done_o)
      assert (bus.req_i && bus.funct3_i == p_f && bus.rs1_val_i == p_a && bus.rs2_val_i == p_b)
        else $error("protocol violation: request changed while busy");
    p_f <= bus.funct3_i;
    p_a <= bus.rs1_val_i;
    p_b <= bus.rs2_val_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return NORM_LAT;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.req_i     = 1'b1;
    bus.funct3_i  = f;
    bus.rs1_val_i = a;
    bus.rs2_val_i = b;
  endtask

  // Starts in the cycle the request is presented; returns in the done cycle.
  task automatic wait_done(output logic [31:0] res, output int lat, output int stl);
    res = '0;
    lat = -1;
    stl = 0;
    for (int k = 0; k < ITER + 10; k++) begin
      #1;
      if (bus.done_o === 1'b1) begin
        lat = k;
        res = bus.result_o;
        break;
      end
      if (bus.stall_o === 1'b1) stl++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat, stl;
    @(negedge clk);
    drive(f, a, b);
    wait_done(res, lat, stl);
    bus.req_i = 1'b0;
    check({name, " result"}, res, exp);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " stall cycles"}, 32'(stl), 32'(exp_lat == 1 ? 1 : NORM_LAT));
    last_res = res;
    @(negedge clk);
    #1;
    check({name, " done pulse"}, {31'b0, bus.done_o}, 32'd0);
    check({name, " result hold"}, bus.result_o, exp);
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic [2:0]  f;
    int lat, stl;

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, NORM_LAT};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NORM_LAT};
    vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, NORM_LAT};
    vecs[3]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, NORM_LAT};
    vecs[4]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, NORM_LAT};
    vecs[5]  = '{3'd5, 32'd100,      32'd7,        32'd14,       NORM_LAT};
    vecs[6]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[7]  = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
    vecs[8]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[9]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
    vecs[10] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, NORM_LAT};
    vecs[11] = '{3'd6, 32'd5,        32'd0,        32'd5,        1};

    bus.req_i = 1'b0; bus.funct3_i = '0; bus.rs1_val_i = '0; bus.rs2_val_i = '0; bus.flush_i = 1'b0;

    // Reset state
    #12;
    check("reset busy", {31'b0, bus.busy_o}, 32'd0);
    check("reset done", {31'b0, bus.done_o}, 32'd0);
    check("reset stall", {31'b0, bus.stall_o}, 32'd0);
    check("reset result", bus.result_o, 32'd0);
    bus.req_i = 1'b1;
    #1;
    check("reset stall follows req", {31'b0, bus.stall_o}, 32'd1);
    bus.req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Flush in the middle of CALC
    @(negedge clk);
    drive(3'd0, 32'd123, 32'd456);
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    bus.req_i = 1'b0;
    #1;
    check("flush done suppressed", {31'b0, bus.done_o}, 32'd0);
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    check("flush busy", {31'b0, bus.busy_o}, 32'd0);
    check("flush done", {31'b0, bus.done_o}, 32'd0);
    check("flush result held", bus.result_o, last_res);
    do_op("divu after flush", 3'd5, 32'd9, 32'd3, 32'd3, NORM_LAT);

    // Flush while idle must not accept
    @(negedge clk);
    drive(3'd0, 32'd2, 32'd3);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.req_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    check("idle flush no accept", {31'b0, bus.busy_o}, 32'd0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    drive(3'd0, 32'h1234, 32'h5678);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", {31'b0, bus.busy_o}, 32'd0);
    check("async rst done", {31'b0, bus.done_o}, 32'd0);
    check("async rst result", bus.result_o, 32'd0);
    check("async rst stall", {31'b0, bus.stall_o}, 32'd1);
    bus.req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op("mul after reset", 3'd0, 32'h1234, 32'h5678, 32'h0626_0060, NORM_LAT);

    // Back-to-back MUL then DIV with no bubble
    @(negedge clk);
    drive(3'd0, 32'd6, 32'd7);
    wait_done(res, lat, stl);
    check("b2b mul result", res, 32'd42);
    check("b2b mul latency", 32'(lat), 32'(NORM_LAT));
    drive(3'd4, 32'd100, 32'hFFFFFFF9);
    @(negedge clk);
    #1;
    check("b2b idle busy", {31'b0, bus.busy_o}, 32'd0);
    check("b2b result holds", bus.result_o, 32'd42);
    @(negedge clk);
    #1;
    check("b2b second accepted", {31'b0, bus.busy_o}, 32'd1);
    check("b2b result holds in calc", bus.result_o, 32'd42);
    wait_done(res, lat, stl);
    bus.req_i = 1'b0;
    check("b2b div result", res, 32'hFFFFFFF2);
    check("b2b div latency", 32'(lat), 32'(NORM_LAT - 1));

    // Randomized against the arithmetic reference model
    for (int n = 0; n < 150; n++) begin
      f = 3'($urandom_range(0, 7));
      a = rnd_operand();
      b = rnd_operand();
      do_op($sformatf("rand%0d f%0d %h %h", n, f, a, b), f, a, b, ref_model(f, a, b), ref_lat(f, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; equals GPR_WIDTH.
REQ-002 Parameter ITER, default 32: iterations per operation; equals XLEN.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  1  EXE holds an RV32M instruction.
REQ-006 funct3_i  input  3  M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 rs1_val_i  input  XLEN  operand A, post-forwarding.
REQ-008 rs2_val_i  input  XLEN  operand B, post-forwarding.
REQ-009 flush_i  input  1  abort the current op (branch/jump redirect).
REQ-010 stall_o  output  1  freeze IF/ID/EXE while high.
REQ-011 busy_o  output  1  FSM is not IDLE.
REQ-012 done_o  output  1  result_o valid this cycle.
REQ-013 result_o  output  XLEN  final result, forwarded into alu_val_o by EXE.

Function
REQ-014 FSM states: IDLE, CALC, FINISH.
REQ-015 IDLE and req_i=1 and flush_i=0: latch funct3, operand magnitudes, and sign flags (signed ops only; MULHSU treats rs1 as signed and rs2 as unsigned); go to CALC with counter=0.
REQ-016 IDLE acceptance, division by zero (funct3 4-7, rs2=0): skip CALC and go to FINISH; result is all-ones (DIV/DIVU) or rs1 (REM/REMU).
REQ-017 IDLE acceptance, DIV/REM overflow (rs1=0x80000000, rs2=0xFFFFFFFF): go to FINISH; result is 0x80000000 (DIV) or 0 (REM).
REQ-018 CALC does one iteration per cycle and increments the counter.
- Multiply: radix-2 shift-add into a 2*XLEN accumulator.
- Divide: restoring shift-subtract producing quotient and remainder magnitudes.
REQ-019 CALC with counter=ITER-1: go to FINISH; sign correction is applied on that transition.
- Product is negated if the sign flags differ.
- Quotient is negated if the sign flags differ.
- Remainder takes the sign of rs1.
REQ-020 Result selection: MUL takes the low half; MULH, MULHSU and MULHU take the high half.
REQ-021 FINISH: done_o = ~flush_i; unconditional transition to IDLE.
REQ-022 stall_o = req_i & ~done_o (combinational).
- Normal op accepted at cycle T: stall high T..T+ITER, done_o at T+ITER+1.
- Special case accepted at T: done_o at T+1.
REQ-023 result_o is registered, holds its value outside FINISH, and changes only on entry to FINISH.
REQ-024 flush_i=1 in any state: next state IDLE; no done_o for the aborted op. A flush in IDLE does not accept a request.
REQ-025 A new req_i in the IDLE cycle immediately after FINISH is accepted (back-to-back ops, no bubble).
REQ-026 req_i and operands stay stable while busy_o=1 and flush_i=0; dropping them is a protocol violation flagged by a bench assertion.
REQ-027 Counter is log2(ITER)+1 bits wide and is cleared on entering CALC.

Reset
REQ-028 rst_n_i low, asynchronously: state=IDLE, counter=0, accumulators=0, sign flags=0, result_o=0.
REQ-029 Reset outputs: busy_o=0, done_o=0; stall_o follows REQ-022 and is 0 unless req_i is high.
REQ-030 Reset asserted mid-operation discards the op; the first accept after release restarts it from the beginning.

Structure
REQ-031 The funct3 M-op encodings and the MULDIV instruction IDs go in the shared defines header used by decode and EXE; the FSM state encoding stays local.
REQ-032 One sub-module, muldiv_iter: a combinational single-iteration step (shift-add or shift-subtract). The FSM, counter and registers stay in muldiv_seq.

Verification
REQ-033 MUL 7*(-3) -> stall 33 cycles, done_o at T+33, result 0xFFFFFFEB.
REQ-034 MULHU 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0x00000002 -> result 0xFFFFFFFF.
REQ-035 DIV -7/2 -> result 0xFFFFFFFD. REM -7/2 -> result 0xFFFFFFFF. DIVU 100/7 -> result 14.
REQ-036 Special cases, each with done_o at T+1:
- DIV 5/0 -> 0xFFFFFFFF.
- REMU 5/0 -> 5.
- DIV 0x80000000/-1 -> 0x80000000.
REQ-037 flush_i at CALC cycle 10 -> IDLE next cycle, no done_o, busy_o=0. A following DIVU 9/3 -> 3 after the normal latency.
REQ-038 rst_n_i pulsed mid-CALC -> outputs 0 immediately (asynchronous); back-to-back MUL then DIV -> second accepted the cycle after the first done_o.
